// File: rtl/flit_sink_monitor_pkg.sv
// Shared definitions for the flit sink monitor: flit type codes, error codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package flit_sink_monitor_pkg;

  // Flit type field encodings (MSBs of the flit word)
  localparam int TYPE_NONE = 0;
  localparam int TYPE_HEAD = 1;
  localparam int TYPE_DATA = 2;
  localparam int TYPE_TAIL = 3;

  // Protocol error codes reported on err_code
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ORPHAN   = 3'd1;
  localparam logic [2:0] ERR_NESTHEAD = 3'd2;
  localparam logic [2:0] ERR_VCHMIS   = 3'd3;
  localparam logic [2:0] ERR_BADTYPE  = 3'd4;
  localparam logic [2:0] ERR_LENOVF   = 3'd5;

  // Framing FSM: outside a packet, or between HEAD and TAIL
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  // A single flit may break several rules at once; report only the most severe.
  function automatic logic [2:0] pick_err(
    input logic lenovf,
    input logic vchmis,
    input logic nesthead,
    input logic orphan,
    input logic badtype
  );
    if (lenovf)        return ERR_LENOVF;
    else if (vchmis)   return ERR_VCHMIS;
    else if (nesthead) return ERR_NESTHEAD;
    else if (orphan)   return ERR_ORPHAN;
    else if (badtype)  return ERR_BADTYPE;
    else               return ERR_NONE;
  endfunction

endpackage

// File: rtl/flit_sink_monitor_popcount.sv
// Combinational population count of a W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module flit_popcount #(
  parameter int W  = 66,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_vec,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] w_sum;

  // Ripple sum of set bits; synthesis folds this into an adder tree
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < W; i++) begin
      w_sum = w_sum + CW'(i_vec[i]);
    end
  end

  assign o_cnt = w_sum;

endmodule

// File: rtl/flit_sink_monitor.sv
// Receive-side flit sink: framing checker, packet/flit counters, data-bus toggle accumulator.
// Latency: 1 cycle, all outputs registered from the flit sampled at the previous edge.
// Backpressure: none, every flit presented is consumed.
module flit_sink_monitor
  import flit_sink_monitor_pkg::*;
#(
  parameter int TYPEW  = 2,
  parameter int PAYW   = 64,
  parameter int VCHW   = 2,
  parameter int MAXLEN = 64,
  parameter int CNTW   = 32,
  parameter int ACCW   = 40
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [TYPEW+PAYW-1:0]   idata,
  input  logic                    ivalid,
  input  logic [VCHW-1:0]         ivch,
  input  logic                    clr,
  output logic                    busy,
  output logic [CNTW-1:0]         pkt_cnt,
  output logic [CNTW-1:0]         flit_cnt,
  output logic [7:0]              last_len,
  output logic [ACCW-1:0]         toggle_acc,
  output logic                    err,
  output logic [2:0]              err_code
);

  localparam int DW   = TYPEW + PAYW;
  localparam int PCW  = $clog2(DW + 1);
  localparam int LENW = $clog2(MAXLEN + 1);

  // Architectural state
  state_t            r_state;
  logic [LENW-1:0]   r_len;
  logic [VCHW-1:0]   r_vch;
  logic [DW-1:0]     r_prev;
  logic [CNTW-1:0]   r_pkt_cnt;
  logic [CNTW-1:0]   r_flit_cnt;
  logic [7:0]        r_last_len;
  logic [ACCW-1:0]   r_toggle_acc;
  logic              r_err;
  logic [2:0]        r_err_code;

  // Flit decode
  logic [TYPEW-1:0]  w_type;
  logic              w_is_head;
  logic              w_is_data;
  logic              w_is_tail;

  // Next-state decode
  state_t            w_next_state;
  logic [LENW-1:0]   w_next_len;
  logic [VCHW-1:0]   w_next_vch;
  logic              w_pkt_done;
  logic [LENW-1:0]   w_done_len;
  logic [31:0]       w_done_len32;
  logic [7:0]        w_last_len_sat;
  logic              w_orphan;
  logic              w_nesthead;
  logic              w_vchmis;
  logic              w_badtype;
  logic              w_lenovf;
  logic [2:0]        w_err_code;

  // Toggle accounting
  logic [DW-1:0]     w_diff;
  logic [PCW-1:0]    w_pop;
  logic [ACCW:0]     w_acc_sum;

  assign w_type    = idata[DW-1 -: TYPEW];
  assign w_is_head = (w_type == TYPEW'(TYPE_HEAD));
  assign w_is_data = (w_type == TYPEW'(TYPE_DATA));
  assign w_is_tail = (w_type == TYPEW'(TYPE_TAIL));

  // A TAIL completes a packet of the current length plus itself; this never exceeds MAXLEN
  assign w_done_len     = r_len + LENW'(1);
  assign w_done_len32   = 32'(w_done_len);
  assign w_last_len_sat = (w_done_len32 > 32'd255) ? 8'd255 : w_done_len32[7:0];

  // Framing rules: work out the next FSM state and which rules the current flit breaks
  always_comb begin
    w_next_state = r_state;
    w_next_len   = r_len;
    w_next_vch   = r_vch;
    w_pkt_done   = 1'b0;
    w_orphan     = 1'b0;
    w_nesthead   = 1'b0;
    w_vchmis     = 1'b0;
    w_badtype    = 1'b0;
    w_lenovf     = 1'b0;
    if (ivalid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_head) begin
            w_next_state = ST_BODY;
            w_next_len   = LENW'(1);
            w_next_vch   = ivch;
          end else if (w_is_data || w_is_tail) begin
            w_orphan = 1'b1;
          end else begin
            w_badtype = 1'b1;
          end
        end
        ST_BODY: begin
          // Checked against the captured channel even for a nested HEAD
          w_vchmis = (ivch != r_vch);
          if (w_is_head) begin
            w_nesthead = 1'b1;
            w_next_len = LENW'(1);
            w_next_vch = ivch;
          end else if (w_is_data) begin
            w_next_len = r_len + LENW'(1);
          end else if (w_is_tail) begin
            w_pkt_done   = 1'b1;
            w_next_state = ST_IDLE;
            w_next_len   = '0;
          end else begin
            w_badtype = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_len   = '0;
        end
      endcase
      // Packet hit the length limit with no TAIL yet: abandon it, the rest arrives as orphans
      if (w_next_state == ST_BODY && w_next_len >= LENW'(MAXLEN)) begin
        w_lenovf     = 1'b1;
        w_next_state = ST_IDLE;
        w_next_len   = '0;
      end
    end
    w_err_code = pick_err(w_lenovf, w_vchmis, w_nesthead, w_orphan, w_badtype);
  end

  // FSM, packet/flit counters and sticky first-error capture
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_vch      <= '0;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_last_len <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (clr) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_vch      <= '0;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_last_len <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state <= w_next_state;
      r_len   <= w_next_len;
      r_vch   <= w_next_vch;
      if (ivalid && (r_flit_cnt != {CNTW{1'b1}})) begin
        r_flit_cnt <= r_flit_cnt + CNTW'(1);
      end
      if (w_pkt_done) begin
        if (r_pkt_cnt != {CNTW{1'b1}}) begin
          r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
        end
        r_last_len <= w_last_len_sat;
      end
      if ((w_err_code != ERR_NONE) && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end
    end
  end

  assign w_diff = idata ^ r_prev;

  flit_popcount #(
    .W  (DW),
    .CW (PCW)
  ) u_popcount (
    .i_vec (w_diff),
    .o_cnt (w_pop)
  );

  // One guard bit catches accumulator overflow so it can pin at all-ones
  assign w_acc_sum = {1'b0, r_toggle_acc} + (ACCW+1)'(w_pop);

  // Bus switching activity, every cycle regardless of ivalid
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_prev       <= '0;
      r_toggle_acc <= '0;
    end else if (clr) begin
      r_prev       <= idata;
      r_toggle_acc <= '0;
    end else begin
      r_prev       <= idata;
      r_toggle_acc <= w_acc_sum[ACCW] ? {ACCW{1'b1}} : w_acc_sum[ACCW-1:0];
    end
  end

  assign busy       = (r_state == ST_BODY);
  assign pkt_cnt    = r_pkt_cnt;
  assign flit_cnt   = r_flit_cnt;
  assign last_len   = r_last_len;
  assign toggle_acc = r_toggle_acc;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Self-checking bench for flit_sink_monitor: table vectors, directed corner sequences, random vs. model.
// Two instances share the stimulus: default MAXLEN=64 and a short MAXLEN=8 copy.
// The model tracks packets at the flit level and is stepped at each rising edge.
module tb_flit_sink_monitor;

  logic        clk = 1'b0;
  logic        rst_;
  logic [65:0] idata;
  logic        ivalid;
  logic [1:0]  ivch;
  logic        clr;

  logic        busy_a,  busy_b;
  logic [31:0] pkt_a,   pkt_b;
  logic [31:0] flit_a,  flit_b;
  logic [7:0]  last_a,  last_b;
  logic [39:0] tog_a,   tog_b;
  logic        err_a,   err_b;
  logic [2:0]  code_a,  code_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flit_sink_monitor dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .busy(busy_a), .pkt_cnt(pkt_a), .flit_cnt(flit_a), .last_len(last_a),
    .toggle_acc(tog_a), .err(err_a), .err_code(code_a)
  );

  flit_sink_monitor #(.MAXLEN(8)) dut8 (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .busy(busy_b), .pkt_cnt(pkt_b), .flit_cnt(flit_b), .last_len(last_b),
    .toggle_acc(tog_b), .err(err_b), .err_code(code_b)
  );

  typedef struct {
    bit          in_pkt;
    int          len;
    logic [1:0]  vch;
    longint      pkt;
    longint      flit;
    int          last;
    longint      tog;
    bit          err;
    int          code;
    logic [65:0] prev;
  } m_t;

  m_t m64, m8;

  function automatic m_t m_step(m_t m, int maxlen, logic [65:0] d, bit v, logic [1:0] ch, bit c);
    m_t r = m;
    bit [5:0] viol = '0;
    int ty;
    int order [5] = '{5, 3, 2, 1, 4};
    if (c) begin
      r = '{default:0};
      r.prev = d;
      return r;
    end
    r.tog += $countones(d ^ r.prev);
    r.prev = d;
    if (!v) return r;
    r.flit++;
    ty = int'(d[65:64]);
    if (r.in_pkt && ch != r.vch) viol[3] = 1'b1;
    case (ty)
      1: begin
        if (r.in_pkt) viol[2] = 1'b1;
        r.in_pkt = 1'b1; r.len = 1; r.vch = ch;
      end
      2: begin
        if (!r.in_pkt) viol[1] = 1'b1;
        else r.len++;
      end
      3: begin
        if (!r.in_pkt) viol[1] = 1'b1;
        else begin
          r.pkt++;
          r.last = (r.len + 1 > 255) ? 255 : r.len + 1;
          r.in_pkt = 1'b0;
        end
      end
      default: viol[4] = 1'b1;
    endcase
    if (r.in_pkt && r.len >= maxlen) begin
      viol[5] = 1'b1;
      r.in_pkt = 1'b0;
    end
    if (!r.err) begin
      for (int k = 0; k < 5; k++) begin
        if (!r.err && viol[order[k]]) begin
          r.err = 1'b1;
          r.code = order[k];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [65:0] fl(int ty, logic [63:0] pay);
    logic [1:0] t;
    t = ty[1:0];
    return {t, pay};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vs(string tag, m_t m, logic b, logic [31:0] pc, logic [31:0] fc,
                        logic [7:0] ll, logic [39:0] ta, logic e, logic [2:0] ec);
    chk({tag, ".busy"},     64'(b),  64'(m.in_pkt));
    chk({tag, ".pkt_cnt"},  64'(pc), 64'(m.pkt));
    chk({tag, ".flit_cnt"}, 64'(fc), 64'(m.flit));
    chk({tag, ".last_len"}, 64'(ll), 64'(m.last));
    chk({tag, ".toggle"},   64'(ta), 64'(m.tog));
    chk({tag, ".err"},      64'(e),  64'(m.err));
    chk({tag, ".err_code"}, 64'(ec), 64'(m.code));
  endtask

  // Present one cycle of inputs, step both models on the edge, return 1 time unit later
  task automatic cyc(logic [65:0] d, bit v, logic [1:0] ch, bit c);
    idata = d; ivalid = v; ivch = ch; clr = c;
    @(posedge clk);
    m64 = m_step(m64, 64, d, v, ch, c);
    m8  = m_step(m8,  8,  d, v, ch, c);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0; ivalid = 1'b0; clr = 1'b0; idata = '0; ivch = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ = 1'b1;
    m64 = '{default:0};
    m8  = '{default:0};
  endtask

  typedef struct {
    int         ty;
    logic [1:0] ch;
    bit         v;
    bit         exp_busy;
    int         exp_flit;
    int         exp_pkt;
    bit         exp_err;
    int         exp_code;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [65:0] ones;
    logic [65:0] d;
    logic [1:0]  ch;
    bit          v, c;
    int          r;

    ones = '1;
    rst_ = 1'b1; ivalid = 1'b0; clr = 1'b0; idata = '0; ivch = '0;

    // Orphan TAIL first, then a packet with a channel mismatch: first error is kept
    tbl[0] = '{ty:3, ch:2'd0, v:1'b1, exp_busy:1'b0, exp_flit:1, exp_pkt:0, exp_err:1'b1, exp_code:1};
    tbl[1] = '{ty:1, ch:2'd0, v:1'b1, exp_busy:1'b1, exp_flit:2, exp_pkt:0, exp_err:1'b1, exp_code:1};
    tbl[2] = '{ty:2, ch:2'd2, v:1'b1, exp_busy:1'b1, exp_flit:3, exp_pkt:0, exp_err:1'b1, exp_code:1};
    tbl[3] = '{ty:3, ch:2'd0, v:1'b1, exp_busy:1'b0, exp_flit:4, exp_pkt:1, exp_err:1'b1, exp_code:1};
    tbl[4] = '{ty:2, ch:2'd0, v:1'b0, exp_busy:1'b0, exp_flit:4, exp_pkt:1, exp_err:1'b1, exp_code:1};

    // Reset state
    rst_ = 1'b0;
    #2;
    chk("reset.busy", 64'(busy_a), 64'd0);
    chk("reset.pkt",  64'(pkt_a),  64'd0);
    chk("reset.flit", 64'(flit_a), 64'd0);
    chk("reset.last", 64'(last_a), 64'd0);
    chk("reset.tog",  64'(tog_a),  64'd0);
    chk("reset.err",  64'(err_a),  64'd0);
    chk("reset.code", 64'(code_a), 64'd0);
    do_reset();

    // Clean 22-flit packet on vch 1
    cyc(fl(1, 64'h1111), 1'b1, 2'd1, 1'b0);
    chk("pkt22.busy_head", 64'(busy_a), 64'd1);
    for (int i = 0; i < 20; i++) cyc(fl(2, 64'(i * 7 + 3)), 1'b1, 2'd1, 1'b0);
    cyc(fl(3, 64'hFFFF), 1'b1, 2'd1, 1'b0);
    chk("pkt22.pkt",  64'(pkt_a),  64'd1);
    chk("pkt22.flit", 64'(flit_a), 64'd22);
    chk("pkt22.last", 64'(last_a), 64'd22);
    chk("pkt22.err",  64'(err_a),  64'd0);
    chk("pkt22.busy", 64'(busy_a), 64'd0);

    // Toggle accumulation on bubbles
    do_reset();
    for (int i = 0; i < 10; i++) cyc((i % 2 == 0) ? ones : 66'd0, 1'b0, 2'd0, 1'b0);
    chk("toggle.acc",  64'(tog_a),  64'd660);
    chk("toggle.flit", 64'(flit_a), 64'd0);
    chk("toggle.pkt",  64'(pkt_a),  64'd0);

    // Table vectors
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(fl(tbl[i].ty, 64'hA5A5_0000 + 64'(i)), tbl[i].v, tbl[i].ch, 1'b0);
      chk($sformatf("tbl%0d.busy", i), 64'(busy_a), 64'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d.flit", i), 64'(flit_a), 64'(tbl[i].exp_flit));
      chk($sformatf("tbl%0d.pkt", i),  64'(pkt_a),  64'(tbl[i].exp_pkt));
      chk($sformatf("tbl%0d.err", i),  64'(err_a),  64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d.code", i), 64'(code_a), 64'(tbl[i].exp_code));
    end

    // Length overflow on the MAXLEN=8 instance
    do_reset();
    cyc(fl(1, 64'd0), 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(fl(2, 64'(i)), 1'b1, 2'd0, 1'b0);
    chk("lenovf.busy_7th", 64'(busy_b), 64'd1);
    chk("lenovf.err_7th",  64'(err_b),  64'd0);
    cyc(fl(2, 64'd99), 1'b1, 2'd0, 1'b0);
    chk("lenovf.code", 64'(code_b), 64'd5);
    chk("lenovf.busy", 64'(busy_b), 64'd0);
    chk("lenovf.err",  64'(err_b),  64'd1);
    cyc(fl(3, 64'd0), 1'b1, 2'd0, 1'b0);
    chk("lenovf.pkt",       64'(pkt_b),  64'd0);
    chk("lenovf.code_kept", 64'(code_b), 64'd5);

    // Async reset mid-packet
    do_reset();
    cyc(fl(1, 64'd5), 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(fl(2, 64'(i)), 1'b1, 2'd0, 1'b0);
    rst_ = 1'b0; ivalid = 1'b0;
    #2;
    chk("midrst.busy", 64'(busy_a), 64'd0);
    chk("midrst.flit", 64'(flit_a), 64'd0);
    chk("midrst.tog",  64'(tog_a),  64'd0);
    chk("midrst.code", 64'(code_a), 64'd0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    m64 = '{default:0};
    m8  = '{default:0};
    cyc(fl(2, 64'd7), 1'b1, 2'd0, 1'b0);
    cyc(fl(3, 64'd8), 1'b1, 2'd0, 1'b0);
    chk("midrst.code_after", 64'(code_a), 64'd1);
    chk("midrst.pkt_after",  64'(pkt_a),  64'd0);
    chk("midrst.flit_after", 64'(flit_a), 64'd2);

    // Synchronous clear
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(fl(1, 64'(i)), 1'b1, 2'd0, 1'b0);
      cyc(fl(3, 64'(i)), 1'b1, 2'd0, 1'b0);
    end
    cyc(fl(2, 64'd1), 1'b1, 2'd0, 1'b0);
    chk("clr.pre_pkt", 64'(pkt_a), 64'd5);
    chk("clr.pre_err", 64'(err_a), 64'd1);
    cyc(fl(1, 64'd42), 1'b1, 2'd0, 1'b1);
    chk("clr.pkt",  64'(pkt_a),  64'd0);
    chk("clr.flit", 64'(flit_a), 64'd0);
    chk("clr.err",  64'(err_a),  64'd0);
    chk("clr.code", 64'(code_a), 64'd0);
    chk("clr.last", 64'(last_a), 64'd0);
    chk("clr.tog",  64'(tog_a),  64'd0);
    chk("clr.busy", 64'(busy_a), 64'd0);
    cyc(fl(1, 64'd42), 1'b1, 2'd0, 1'b0);
    cyc(fl(3, 64'd43), 1'b1, 2'd0, 1'b0);
    chk("clr.post_pkt",  64'(pkt_a),  64'd1);
    chk("clr.post_last", 64'(last_a), 64'd2);
    chk("clr.post_err",  64'(err_a),  64'd0);

    // Random traffic against the model on both instances
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
      end else begin
        r  = $urandom_range(0, 99);
        d  = fl((r < 15) ? 1 : (r < 75) ? 2 : (r < 95) ? 3 : 0, {$urandom, $urandom});
        ch = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        v  = ($urandom_range(0, 99) < 85);
        c  = ($urandom_range(0, 199) == 0);
        cyc(d, v, ch, c);
        chk_vs("rand64", m64, busy_a, pkt_a, flit_a, last_a, tog_a, err_a, code_a);
        chk_vs("rand8",  m8,  busy_b, pkt_b, flit_b, last_b, tog_b, err_b, code_b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_sink_monitor.md
Name: flit_sink_monitor

Overview:
- Receive-side endpoint for the router flit interface ({type, payload}, valid, vch).
- Sits on a mux/router output port during characterization runs and consumes every flit; no backpressure.
- Checks HEAD/DATA/TAIL framing and counts packets and flits.
- Accumulates bit-toggle activity on the data bus as a switching-energy proxy.

Parameters:
- TYPEW, 2, flit type field width (MSBs of idata)
- PAYW, 64, payload width
- VCHW, 2, virtual-channel id width
- MAXLEN, 64, maximum legal packet length in flits, HEAD and TAIL included
- CNTW, 32, width of packet/flit counters
- ACCW, 40, width of toggle accumulator

Ports:
- clk  in  1  clock
- rst_  in  1  asynchronous active-low reset
- idata  in  TYPEW+PAYW  incoming flit
- ivalid  in  1  flit valid
- ivch  in  VCHW  flit virtual channel
- clr  in  1  synchronous clear of counters and error state
- busy  out  1  packet in progress
- pkt_cnt  out  CNTW  completed packets
- flit_cnt  out  CNTW  accepted valid flits
- last_len  out  8  length of last completed packet
- toggle_acc  out  ACCW  cumulative Hamming distance of idata, cycle to cycle
- err  out  1  sticky protocol error
- err_code  out  3  code of first error

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; previous-data register 0.
- Outputs are registered and reflect the flit sampled at the previous rising edge (1-cycle latency).
- Type encodings: NONE=0, HEAD=1, DATA=2, TAIL=3.
- Flit accepted when ivalid=1; every accepted flit increments flit_cnt. ivalid=0 is a bubble: no FSM change.
- FSM IDLE:
  - HEAD: go to BODY, len=1, capture ivch.
  - DATA or TAIL: error ORPHAN(1); stay IDLE.
  - NONE with valid: error BADTYPE(4).
- FSM BODY:
  - DATA: len+1.
  - TAIL: pkt_cnt+1, last_len=len+1, go to IDLE.
  - HEAD: error NESTHEAD(2); restart packet with len=1 and new vch.
  - NONE with valid: BADTYPE; stay in BODY.
  - Any valid flit whose ivch differs from the captured vch: error VCHMIS(3); flit is still counted.
  - len reaching MAXLEN without TAIL: error LENOVF(5); return to IDLE; the remainder of the packet is treated as orphans.
- busy = (state==BODY).
- Toggle accounting: every cycle, independent of ivalid, toggle_acc += popcount(idata ^ prev); prev <= idata.
- Saturation: counters and accumulator saturate at all-ones with no wrap; last_len saturates at 255.
- Error priority when one flit violates several rules: LENOVF > VCHMIS > NESTHEAD > ORPHAN > BADTYPE.
- err is sticky. err_code holds the first error and is not overwritten until clr.
- clr=1: zero counters, toggle_acc, err, err_code, last_len; FSM to IDLE; the flit on that cycle is ignored; prev is loaded with idata.
- Async reset asserted mid-packet: immediate return to reset state. The first flit after reset release must be HEAD, otherwise ORPHAN.

Decomposition:
- Shared package holds the type encodings (TYPE_NONE/HEAD/DATA/TAIL), error code constants, and the FSM state enum.
- One sub-module, flit_popcount: combinational popcount of the TYPEW+PAYW XOR vector, result width clog2(TYPEW+PAYW+1).
- FSM, counters and accumulator stay in the top.

Test Plan:
- Packet on vch=1: HEAD, 20 DATA, TAIL, no bubbles -> pkt_cnt=1, flit_cnt=22, last_len=22, err=0, busy low after TAIL.
- idata alternating all-zeros / all-ones (66 bits) for 10 cycles with ivalid=0, starting from prev=0 -> toggle_acc=660, flit_cnt=0, pkt_cnt=0.
- TAIL while IDLE, then HEAD, DATA(vch=2 vs head vch=0), TAIL -> err=1, err_code=1 (first error kept), pkt_cnt=1, flit_cnt=4.
- MAXLEN=8: HEAD + 7 DATA -> err_code=5, busy=0 on the 8th flit; following TAIL does not increment pkt_cnt.
- HEAD, 3 DATA, rst_ low for 1 cycle, then DATA, TAIL -> all outputs 0 during reset; afterwards err_code=1, pkt_cnt=0, flit_cnt=2.
- After a run with pkt_cnt=5 and err=1, pulse clr -> all counters, err and err_code 0 the next cycle; a following HEAD/TAIL pair gives pkt_cnt=1, last_len=2.
